// File: rtl/pocq_sched_if.sv
// POCQ issue-side bundle: slot events in, issue offer and slot status out.
// Latency: not applicable (wires only).
// Backpressure: issue_vld/issue_rdy handshake; all other signals are single-cycle pulses or status.
//
// Ports (master = fill side + pipeline, slave = scheduler):
//   alloc_vld/alloc_idx    slot written by the fill side
//   wake_vld/wake_idx      wake one sleeping slot; wake_all wakes every sleeping slot
//   issue_vld/issue_idx    slot offered to the pipeline; issue_rdy accepts it
//   retire_vld/retire_idx  slot completed and freed
//   retry_vld/retry_idx    slot bounced back to sleep
//   free_vec, occupancy, full, empty, err   registered status
interface pocq_sched_if #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
);
    logic             alloc_vld;
    logic [IDX_W-1:0] alloc_idx;
    logic             wake_vld;
    logic [IDX_W-1:0] wake_idx;
    logic             wake_all;
    logic             issue_vld;
    logic [IDX_W-1:0] issue_idx;
    logic             issue_rdy;
    logic             retire_vld;
    logic [IDX_W-1:0] retire_idx;
    logic             retry_vld;
    logic [IDX_W-1:0] retry_idx;
    logic [DEPTH-1:0] free_vec;
    logic [IDX_W:0]   occupancy;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output alloc_vld, alloc_idx, wake_vld, wake_idx, wake_all, issue_rdy,
               retire_vld, retire_idx, retry_vld, retry_idx,
        input  issue_vld, issue_idx, free_vec, occupancy, full, empty, err
    );

    modport slave (
        input  alloc_vld, alloc_idx, wake_vld, wake_idx, wake_all, issue_rdy,
               retire_vld, retire_idx, retry_vld, retry_idx,
        output issue_vld, issue_idx, free_vec, occupancy, full, empty, err
    );
endinterface

// File: rtl/pocq_sched.sv
// HN-F POCQ issue scheduler: per-slot sleep/wake/issue/retire tracking with round-robin issue.
// Latency: slot READY at edge N is offered from edge N+1; back-to-back issue at one slot per cycle.
// Backpressure: an offer (issue_vld/issue_idx) is locked until issue_rdy; newer READY slots never preempt it.
//
// Ports: clk, rst_n (async active-low), bus (pocq_sched_if.slave) carrying alloc/wake/retire/retry
//        events, the issue handshake and the registered free_vec/occupancy/full/empty/err status.
module pocq_sched #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    pocq_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_SLEEP  = 2'd1,
        S_READY  = 2'd2,
        S_ACTIVE = 2'd3
    } slot_st_e;

    slot_st_e         st_q [DEPTH];
    slot_st_e         st_d [DEPTH];

    logic             issue_vld_q;
    logic [IDX_W-1:0] issue_idx_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [DEPTH-1:0] free_vec_q;
    logic [IDX_W:0]   occ_q;
    logic             full_q;
    logic             empty_q;
    logic             err_q;

    logic             hs;
    logic [DEPTH-1:0] alloc_hit;
    logic [DEPTH-1:0] wake_hit;
    logic [DEPTH-1:0] hs_hit;
    logic [DEPTH-1:0] ret_hit;
    logic [DEPTH-1:0] rty_hit;
    logic [DEPTH-1:0] elig;
    logic             err_d;
    logic [DEPTH-1:0] free_d;
    logic [IDX_W:0]   occ_d;
    logic [IDX_W-1:0] search_base;
    logic [IDX_W-1:0] cand;
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;

    assign hs = issue_vld_q & bus.issue_rdy;

    // Decode every event to a per-slot hit vector.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            alloc_hit[i] = bus.alloc_vld  && (bus.alloc_idx  == IDX_W'(i));
            wake_hit[i]  = bus.wake_all   || (bus.wake_vld && (bus.wake_idx == IDX_W'(i)));
            hs_hit[i]    = hs             && (issue_idx_q    == IDX_W'(i));
            ret_hit[i]   = bus.retire_vld && (bus.retire_idx == IDX_W'(i));
            rty_hit[i]   = bus.retry_vld  && (bus.retry_idx  == IDX_W'(i));
        end
    end

    // Slot transitions, judged against the registered state only.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i] = st_q[i];
            unique case (st_q[i])
                S_FREE:   if (alloc_hit[i]) st_d[i] = S_SLEEP;
                S_SLEEP:  if (wake_hit[i])  st_d[i] = S_READY;
                S_READY:  if (hs_hit[i])    st_d[i] = S_ACTIVE;
                S_ACTIVE: begin
                    if (ret_hit[i])
                        st_d[i] = S_FREE;
                    else if (rty_hit[i])
                        // A wake landing with the retry must not be lost.
                        st_d[i] = wake_hit[i] ? S_READY : S_SLEEP;
                end
            endcase
            if (alloc_hit[i] && (st_q[i] != S_FREE))
                err_d = 1'b1;
            if ((ret_hit[i] || rty_hit[i]) && (st_q[i] != S_ACTIVE))
                err_d = 1'b1;
            if (ret_hit[i] && rty_hit[i])
                err_d = 1'b1;
        end
    end

    // Status derived from next state so the outputs are plain registers.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_d[i] = (st_d[i] == S_FREE);
            if (st_d[i] != S_FREE)
                occ_d = occ_d + (IDX_W+1)'(1);
        end
    end

    // Round-robin pick over slots READY at the start of this cycle. The slot
    // accepted this cycle is excluded and the search starts just past it, so a
    // new winner can be offered on the very next edge.
    always_comb begin
        search_base = hs ? (issue_idx_q + IDX_W'(1)) : rr_ptr_q;
        win_vld     = 1'b0;
        win_idx     = '0;
        cand        = '0;
        for (int i = 0; i < DEPTH; i++)
            elig[i] = (st_q[i] == S_READY) && !hs_hit[i];
        for (int j = 0; j < DEPTH; j++) begin
            cand = search_base + IDX_W'(j);
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                st_q[i] <= S_FREE;
            issue_vld_q <= 1'b0;
            issue_idx_q <= '0;
            rr_ptr_q    <= '0;
            free_vec_q  <= '1;
            occ_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                st_q[i] <= st_d[i];
            if (hs)
                rr_ptr_q <= issue_idx_q + IDX_W'(1);
            // Offer is locked while it waits for issue_rdy.
            if (!issue_vld_q || bus.issue_rdy) begin
                issue_vld_q <= win_vld;
                issue_idx_q <= win_idx;
            end
            free_vec_q <= free_d;
            occ_q      <= occ_d;
            full_q     <= (occ_d == (IDX_W+1)'(DEPTH));
            empty_q    <= (occ_d == '0);
            err_q      <= err_d;
        end
    end

    assign bus.issue_vld = issue_vld_q;
    assign bus.issue_idx = issue_idx_q;
    assign bus.free_vec  = free_vec_q;
    assign bus.occupancy = occ_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_pocq_sched.sv
// Bench for pocq_sched: directed scenarios plus random traffic against a slot-level model.
// Latency: model predicts registered outputs one edge after each stimulus cycle.
// Backpressure: issue_rdy randomised; the model holds its offer until accepted.
module tb_pocq_sched;
    localparam int DEPTH = 16;

    typedef enum int {M_FREE, M_SLEEP, M_READY, M_ACTIVE} mst_e;

    typedef struct {
        bit alloc; int a_idx;
        bit wake;  int w_idx;
        bit wall;  bit rdy;
        bit ret;   int r_idx;
        bit rty;   int y_idx;
    } stim_t;

    typedef struct {
        bit vld; int idx; int fv; int occ; bit full; bit empty; bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pocq_sched_if #(.DEPTH(DEPTH)) bus();
    pocq_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sbq[$];

    // Reference model: slot life-cycle in plain arrays.
    mst_e ms [DEPTH];
    bit   m_vld;
    int   m_idx;
    int   m_ptr;
    bit   m_err;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    endtask

    function automatic stim_t idle(input bit rdy);
        stim_t s;
        s = '{default: 0};
        s.rdy = rdy;
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) ms[i] = M_FREE;
        m_vld = 0; m_idx = 0; m_ptr = 0; m_err = 0;
    endfunction

    function automatic bit woken(input stim_t s, input int k);
        return s.wall || (s.wake && s.w_idx == k);
    endfunction

    function automatic void model_step(input stim_t s);
        mst_e ns [DEPTH];
        bit   hs;
        bit   found;
        hs = m_vld && s.rdy;
        ns = ms;
        if (s.alloc) begin
            if (ms[s.a_idx] == M_FREE) ns[s.a_idx] = M_SLEEP;
            else m_err = 1;
        end
        for (int k = 0; k < DEPTH; k++)
            if (ms[k] == M_SLEEP && woken(s, k)) ns[k] = M_READY;
        if (hs) ns[m_idx] = M_ACTIVE;
        if (s.ret && s.rty && s.r_idx == s.y_idx) begin
            m_err = 1;
            if (ms[s.r_idx] == M_ACTIVE) ns[s.r_idx] = M_FREE;
        end else begin
            if (s.ret) begin
                if (ms[s.r_idx] == M_ACTIVE) ns[s.r_idx] = M_FREE;
                else m_err = 1;
            end
            if (s.rty) begin
                if (ms[s.y_idx] == M_ACTIVE) ns[s.y_idx] = woken(s, s.y_idx) ? M_READY : M_SLEEP;
                else m_err = 1;
            end
        end
        // A slot is offerable only if it was READY before this edge and still is.
        if (!(m_vld && !s.rdy)) begin
            if (hs) m_ptr = (m_idx + 1) % DEPTH;
            found = 0;
            for (int j = 0; j < DEPTH; j++) begin
                int k;
                k = (m_ptr + j) % DEPTH;
                if (!found && ms[k] == M_READY && ns[k] == M_READY) begin
                    found = 1; m_idx = k;
                end
            end
            m_vld = found;
        end
        ms = ns;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '{default: 0};
        e.vld = m_vld; e.idx = m_idx; e.err = m_err;
        for (int i = 0; i < DEPTH; i++) begin
            if (ms[i] == M_FREE) e.fv = e.fv | (1 << i);
            else e.occ++;
        end
        e.full  = (e.occ == DEPTH);
        e.empty = (e.occ == 0);
        return e;
    endfunction

    function automatic int pick(input mst_e want, input int excl);
        int q[$];
        for (int i = 0; i < DEPTH; i++)
            if (ms[i] == want && i != excl) q.push_back(i);
        if (q.size() == 0) return -1;
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    function automatic stim_t gen(input bit legal);
        stim_t s;
        int    k;
        s = idle($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 9) < 4) begin
            k = legal ? pick(M_FREE, -1) : int'($urandom_range(0, DEPTH - 1));
            if (k >= 0) begin s.alloc = 1; s.a_idx = k; end
        end
        if ($urandom_range(0, 9) < 4) begin s.wake = 1; s.w_idx = $urandom_range(0, DEPTH - 1); end
        if ($urandom_range(0, 19) == 0) s.wall = 1;
        if ($urandom_range(0, 9) < 4) begin
            k = legal ? pick(M_ACTIVE, -1) : int'($urandom_range(0, DEPTH - 1));
            if (k >= 0) begin s.ret = 1; s.r_idx = k; end
        end
        if ($urandom_range(0, 9) < 2) begin
            k = legal ? pick(M_ACTIVE, s.ret ? s.r_idx : -1) : int'($urandom_range(0, DEPTH - 1));
            if (k >= 0) begin s.rty = 1; s.y_idx = k; end
        end
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.alloc_vld  = s.alloc; bus.alloc_idx  = 4'(s.a_idx);
        bus.wake_vld   = s.wake;  bus.wake_idx   = 4'(s.w_idx);
        bus.wake_all   = s.wall;  bus.issue_rdy  = s.rdy;
        bus.retire_vld = s.ret;   bus.retire_idx = 4'(s.r_idx);
        bus.retry_vld  = s.rty;   bus.retry_idx  = 4'(s.y_idx);
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic step(input stim_t s);
        drive(s);
        model_step(s);
        @(posedge clk);
        #1;
        sbq.push_back(model_out());
    endtask

    task automatic do_reset();
        sbq.delete();
        drive(idle(0));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_issue_vld", bus.issue_vld, 0);
        chk("rst_issue_idx", bus.issue_idx, 0);
        chk("rst_free_vec", bus.free_vec, 16'hFFFF);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_err", bus.err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sbq.push_back(model_out());
    endtask

    // Monitor: compares every predicted snapshot against the DUT mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("issue_vld", bus.issue_vld, e.vld);
            if (e.vld) chk("issue_idx", bus.issue_idx, e.idx);
            chk("free_vec", bus.free_vec, e.fv);
            chk("occupancy", bus.occupancy, e.occ);
            chk("full", bus.full, e.full);
            chk("empty", bus.empty, e.empty);
            chk("err", bus.err, e.err);
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b1;
        model_reset();
        drive(idle(0));
        @(posedge clk);
        #1;
        do_reset();

        // 1: single slot alloc, wake, issue, retire.
        s = idle(1); s.alloc = 1; s.a_idx = 3; step(s);
        s = idle(1); s.wake = 1; s.w_idx = 3; step(s);
        step(idle(1));
        chk("t1_issue_vld", bus.issue_vld, 1);
        chk("t1_issue_idx", bus.issue_idx, 3);
        step(idle(1));
        s = idle(1); s.ret = 1; s.r_idx = 3; step(s);
        chk("t1_free_vec", bus.free_vec, 16'hFFFF);
        chk("t1_empty", bus.empty, 1);

        // 2: wake_all on three slots, back-to-back issue 0,1,2.
        for (int i = 0; i < 3; i++) begin s = idle(1); s.alloc = 1; s.a_idx = i; step(s); end
        s = idle(1); s.wall = 1; step(s);
        for (int i = 0; i < 3; i++) begin
            step(idle(1));
            chk("t2_issue_idx", bus.issue_idx, i);
        end
        step(idle(1));
        chk("t2_drained", bus.issue_vld, 0);
        for (int i = 0; i < 3; i++) begin s = idle(1); s.ret = 1; s.r_idx = i; step(s); end

        // 3: locked offer of slot 5 survives a newly ready slot 2.
        s = idle(0); s.alloc = 1; s.a_idx = 5; step(s);
        s = idle(0); s.wake = 1; s.w_idx = 5; s.alloc = 1; s.a_idx = 2; step(s);
        s = idle(0); s.wake = 1; s.w_idx = 2; step(s);
        for (int i = 0; i < 3; i++) begin
            step(idle(0));
            chk("t3_locked_idx", bus.issue_idx, 5);
        end
        step(idle(1));
        chk("t3_next_idx", bus.issue_idx, 2);
        step(idle(1));
        s = idle(0); s.ret = 1; s.r_idx = 5; s.rty = 1; s.y_idx = 2; step(s);
        step(idle(0));

        // 5: retry alone sleeps; retry with wake reissues.
        s = idle(1); s.alloc = 1; s.a_idx = 7; step(s);
        s = idle(1); s.wake = 1; s.w_idx = 2; step(s);
        step(idle(1)); step(idle(1));
        s = idle(1); s.rty = 1; s.y_idx = 2; step(s);
        s = idle(1); s.wake = 1; s.w_idx = 7; step(s);
        step(idle(1)); step(idle(1));
        s = idle(1); s.rty = 1; s.y_idx = 7; step(s);
        for (int i = 0; i < 3; i++) step(idle(1));
        chk("t5_no_reissue", bus.issue_vld, 0);
        s = idle(1); s.wake = 1; s.w_idx = 7; step(s);
        step(idle(1)); step(idle(1));
        s = idle(1); s.rty = 1; s.y_idx = 7; s.wake = 1; s.w_idx = 7; step(s);
        step(idle(0));
        chk("t5_reissue_vld", bus.issue_vld, 1);
        chk("t5_reissue_idx", bus.issue_idx, 7);
        step(idle(1));
        s = idle(0); s.ret = 1; s.r_idx = 7; step(s);

        // Random legal traffic: err must stay clear.
        for (int n = 0; n < 800; n++) step(gen(1));
        do_reset();

        // 4: fill every slot, overflow alloc, alloc colliding with retire.
        for (int i = 0; i < DEPTH; i++) begin s = idle(0); s.alloc = 1; s.a_idx = i; step(s); end
        chk("t4_full", bus.full, 1);
        chk("t4_occupancy", bus.occupancy, 16);
        s = idle(0); s.alloc = 1; s.a_idx = 0; step(s);
        chk("t4_err", bus.err, 1);
        chk("t4_unchanged", bus.occupancy, 16);
        s = idle(1); s.wall = 1; step(s);
        for (int i = 0; i < DEPTH + 1; i++) step(idle(1));
        s = idle(0); s.ret = 1; s.r_idx = 0; s.alloc = 1; s.a_idx = 0; step(s);
        chk("t4_slot0_free", bus.free_vec, 16'h0001);
        chk("t4_occ_after", bus.occupancy, 15);
        do_reset();

        // 6: reset while four slots are ACTIVE and a fifth is offered.
        for (int i = 0; i < 5; i++) begin s = idle(0); s.alloc = 1; s.a_idx = i; step(s); end
        s = idle(0); s.wall = 1; step(s);
        for (int i = 0; i < 5; i++) step(idle(1));
        step(idle(0));
        chk("t6_pre_occ", bus.occupancy, 5);
        chk("t6_pre_vld", bus.issue_vld, 1);
        do_reset();

        // Random traffic including protocol violations.
        for (int n = 0; n < 600; n++) step(gen(1));
        for (int n = 0; n < 400; n++) step(gen(0));
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
